// File: rtl/cdr_serial_tx.sv
// rtl/cdr_serial_tx.sv - CDR link serial transmitter: preamble framing, MSB-first serializer, run-length stuffing.
// Optional PRBS7 data scrambler enabled by defining CDR_TX_SCRAMBLE_EN.
module cdr_serial_tx #(
  parameter int WIDTH        = 8,
  parameter int PREAMBLE_LEN = 16,
  parameter int MAX_RUN      = 5
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             tx_en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sdata,
  output logic             tx_active,
  output logic             stuff_flag,
  output logic             frame_done
);

  localparam int PW = $clog2(PREAMBLE_LEN + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(MAX_RUN + 1);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [RW-1:0]    run_q, run_d;
  logic             sdata_q, sdata_d;
  logic             stuff_q, stuff_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             push, pop, word_end;
  logic [WIDTH-1:0] word;
`ifdef CDR_TX_SCRAMBLE_EN
  logic [6:0]       prbs_q, prbs_d;
  logic             prbs_out;
`endif

  assign din_ready  = !buf_full_q;
  assign sdata      = sdata_q;
  assign tx_active  = active_q;
  assign stuff_flag = stuff_q;
  assign frame_done = done_q;

  always_comb begin
    push      = din_valid && !buf_full_q;
    pop       = 1'b0;
    state_d   = state_q;
    shift_d   = shift_q;
    pre_cnt_d = pre_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sdata_d   = 1'b0;
    stuff_d   = 1'b0;
    active_d  = 1'b0;
    done_d    = 1'b0;
    word_end  = (bit_cnt_q == BW'(WIDTH));
    // At a word boundary the next data bit comes straight from the holding buffer.
    word      = word_end ? buf_q : shift_q;
`ifdef CDR_TX_SCRAMBLE_EN
    prbs_d    = prbs_q;
    prbs_out  = prbs_q[6] ^ prbs_q[5];
`endif
    case (state_q)
      IDLE: begin
        if (tx_en && buf_full_q) begin
          state_d   = PREAMBLE;
          pop       = 1'b1;
          shift_d   = buf_q;
          pre_cnt_d = PW'(1);
          sdata_d   = 1'b1;
          active_d  = 1'b1;
`ifdef CDR_TX_SCRAMBLE_EN
          prbs_d    = 7'h7F;
`endif
        end
      end
      PREAMBLE: begin
        active_d  = 1'b1;
        sdata_d   = ~pre_cnt_q[0];
        pre_cnt_d = pre_cnt_q + PW'(1);
        if (pre_cnt_q == PW'(PREAMBLE_LEN - 1)) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (word_end && !(tx_en && buf_full_q)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          active_d = 1'b1;
          if (word_end) begin
            pop       = 1'b1;
            shift_d   = buf_q;
            bit_cnt_d = '0;
          end
          // Stuff bits hold the shifter, so word timing slips by one cycle.
          if (run_q >= RW'(MAX_RUN)) begin
            sdata_d = ~sdata_q;
            stuff_d = 1'b1;
          end else begin
`ifdef CDR_TX_SCRAMBLE_EN
            sdata_d = word[WIDTH-1] ^ prbs_out;
            prbs_d  = {prbs_q[5:0], prbs_out};
`else
            sdata_d = word[WIDTH-1];
`endif
            shift_d = {word[WIDTH-2:0], 1'b0};
            if (word_end) bit_cnt_d = BW'(1);
            else          bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    buf_d      = push ? din : buf_q;
    buf_full_d = push | (buf_full_q & ~pop);
    if (sdata_d != sdata_q)       run_d = RW'(1);
    else if (run_q < RW'(MAX_RUN)) run_d = run_q + RW'(1);
    else                          run_d = run_q;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shift_q    <= '0;
      pre_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      run_q      <= RW'(1);
      sdata_q    <= 1'b0;
      stuff_q    <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
`ifdef CDR_TX_SCRAMBLE_EN
      prbs_q     <= 7'h7F;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      pre_cnt_q  <= pre_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      run_q      <= run_d;
      sdata_q    <= sdata_d;
      stuff_q    <= stuff_d;
      active_q   <= active_d;
      done_q     <= done_d;
`ifdef CDR_TX_SCRAMBLE_EN
      prbs_q     <= prbs_d;
`endif
    end
  end

endmodule

// File: tb/tb_cdr_serial_tx.sv
// tb/tb_cdr_serial_tx.sv - randomized self-checking bench for cdr_serial_tx against a bit-list reference model.
module tb_cdr_serial_tx;
  localparam int W    = 8;
  localparam int PLEN = 4;
  localparam int MRUN = 5;

  logic         refclk = 1'b0;
  logic         rst_n;
  logic         tx_en;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         sdata;
  logic         tx_active;
  logic         stuff_flag;
  logic         frame_done;

  int vectors = 0;
  int miscompares = 0;

  logic exp_bit[$];
  logic exp_stf[$];

  cdr_serial_tx #(.WIDTH(W), .PREAMBLE_LEN(PLEN), .MAX_RUN(MRUN)) dut (
    .refclk(refclk), .rst_n(rst_n), .tx_en(tx_en), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .sdata(sdata), .tx_active(tx_active),
    .stuff_flag(stuff_flag), .frame_done(frame_done)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line sequence of one frame: alternating preamble, then the
  // words MSB first, with an inverted bit inserted whenever MRUN equal bits
  // precede a data bit.
  task automatic build_model(input logic [W-1:0] words[$]);
    logic last;
    int   run;
    logic d;
    logic [6:0] lfsr;
    logic fb;
    exp_bit.delete();
    exp_stf.delete();
    for (int i = 0; i < PLEN; i++) begin
      exp_bit.push_back((i % 2) == 0);
      exp_stf.push_back(1'b0);
    end
    last = 1'b0;
    run  = 1;
    lfsr = 7'h7F;
    fb   = 1'b0;
    foreach (words[k]) begin
      for (int b = W - 1; b >= 0; b--) begin
        d = words[k][b];
`ifdef CDR_TX_SCRAMBLE_EN
        fb   = lfsr[6] ^ lfsr[5];
        lfsr = {lfsr[5:0], fb};
`endif
        d = d ^ fb;
        if (run == MRUN) begin
          exp_bit.push_back(~last);
          exp_stf.push_back(1'b1);
          last = ~last;
          run  = 1;
        end
        exp_bit.push_back(d);
        exp_stf.push_back(1'b0);
        if (d == last) run++;
        else           run = 1;
        last = d;
      end
    end
  endtask

  // Pushes push_q, optionally drops tx_en once two words are accepted, and
  // compares the observed frame against the model built from frame_q.
  task automatic run_frame(input string tag, input logic [W-1:0] push_q[$],
                           input logic [W-1:0] frame_q[$], input bit drop);
    logic got_bit[$];
    logic got_stf[$];
    int   wi = 0;
    int   done_cnt = 0;
    int   after = 0;
    logic rdy_at_edge = 1'b0;
    int   n;
    build_model(frame_q);
    tx_en = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge refclk);
      if (tx_active) begin
        got_bit.push_back(sdata);
        got_stf.push_back(stuff_flag);
      end
      if (frame_done) done_cnt++;
      if (din_valid && rdy_at_edge) wi++;
      if (drop && wi >= 2) tx_en = 1'b0;
      if (wi < push_q.size()) begin
        din_valid = 1'b1;
        din       = push_q[wi];
      end else begin
        din_valid = 1'b0;
      end
      rdy_at_edge = din_ready;
      if (done_cnt > 0) after++;
      if (after > 3) break;
    end
    din_valid = 1'b0;
    check({tag, " len"}, got_bit.size(), exp_bit.size());
    check({tag, " done"}, done_cnt, 1);
    n = (got_bit.size() < exp_bit.size()) ? got_bit.size() : exp_bit.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s sdata[%0d]", tag, i), got_bit[i], exp_bit[i]);
      check($sformatf("%s stuff[%0d]", tag, i), got_stf[i], exp_stf[i]);
    end
  endtask

  initial begin
    logic [W-1:0] pq[$];
    logic [W-1:0] fq[$];
    int   act;
    int   nw;
    logic fill;
    rst_n = 1'b0; tx_en = 1'b0; din = '0; din_valid = 1'b0;
    repeat (3) @(negedge refclk);
    check("rst sdata", sdata, 0);
    check("rst tx_active", tx_active, 0);
    check("rst din_ready", din_ready, 1);
    rst_n = 1'b1;
    @(negedge refclk);
    check("idle sdata", sdata, 0);
    check("idle tx_active", tx_active, 0);
    check("idle din_ready", din_ready, 1);
    check("idle stuff_flag", stuff_flag, 0);
    check("idle frame_done", frame_done, 0);

    pq = '{8'hA5}; run_frame("a5", pq, pq, 1'b0);
    pq = '{8'hFF}; run_frame("ff", pq, pq, 1'b0);
    pq = '{8'h00, 8'h00}; run_frame("b2b00", pq, pq, 1'b0);

    // tx_en dropped mid-frame: only the first word goes out, second stays buffered.
    pq = '{8'h3C, 8'hC3}; fq = '{8'h3C};
    run_frame("drop", pq, fq, 1'b1);
    check("drop buffer kept", din_ready, 0);
    pq = '{}; fq = '{8'hC3};
    run_frame("resume", pq, fq, 1'b0);

    // Reset during data bit 3 with a second word waiting in the buffer.
    tx_en = 1'b1; din = 8'h00; din_valid = 1'b1;
    @(negedge refclk);
    din_valid = 1'b0;
    act = 0;
    for (int cyc = 0; cyc < 40 && act < PLEN + 3; cyc++) begin
      @(negedge refclk);
      if (tx_active) act++;
      if (din_ready && !din_valid) begin din = 8'h55; din_valid = 1'b1; end
      else din_valid = 1'b0;
    end
    din_valid = 1'b0;
    check("abort reached bit3", act, PLEN + 3);
    rst_n = 1'b0;
    #1;
    check("abort sdata", sdata, 0);
    check("abort tx_active", tx_active, 0);
    @(negedge refclk);
    rst_n = 1'b1;
    act = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge refclk);
      if (frame_done || tx_active) act++;
    end
    check("abort din_ready", din_ready, 1);
    check("abort no activity", act, 0);

    for (int f = 0; f < 20; f++) begin
      pq.delete();
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) begin
        fill = $urandom_range(0, 1);
        if ($urandom_range(0, 2) == 0) pq.push_back({W{fill}});
        else                           pq.push_back(W'($urandom));
      end
      run_frame($sformatf("rnd%0d", f), pq, pq, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
